// File: rtl/cnn_batch_checker.sv
// Batch regression sequencer for the digit classifier.
// Runs every stored image through cnn_top and tallies the verdicts.
module cnn_batch_checker #(
    parameter int NUM_IMAGES     = 16,
    parameter int IDX_W          = 4,
    parameter int CLASS_W        = 4,
    parameter int CNT_W          = 5,
    parameter int SETTLE_CYCLES  = 4,
    parameter int START_HOLD     = 2,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic               abort,
    output logic [IDX_W-1:0]   img_idx,
    input  logic [CLASS_W-1:0] exp_label,
    output logic               cnn_start,
    input  logic               cnn_done,
    input  logic [CLASS_W-1:0] cnn_result,
    output logic               busy,
    output logic               batch_done,
    output logic               all_pass,
    output logic [CNT_W-1:0]   pass_cnt,
    output logic [CNT_W-1:0]   fail_cnt,
    output logic [CNT_W-1:0]   timeout_cnt,
    output logic               mismatch,
    output logic [IDX_W-1:0]   first_fail_idx,
    output logic [CLASS_W-1:0] first_fail_result,
    output logic               first_fail_valid
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int HW = $clog2(START_HOLD + 1);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [HW-1:0]    HOLD_LAST   = HW'(START_HOLD - 1);
    localparam logic [WW-1:0]    WD_LIMIT    = WW'(TIMEOUT_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NUM_IMAGES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_START,
        S_WAIT,
        S_CHECK,
        S_NEXT,
        S_DONE
    } state_t;

    state_t             state;
    logic [SW-1:0]      settle_cnt;
    logic [HW-1:0]      hold_cnt;
    logic [WW-1:0]      wdog;
    logic               done_prev;
    logic               tmo_q;
    logic [CLASS_W-1:0] res_q;

    logic done_rise;
    logic chk_fail;

    assign done_rise = !done_prev && cnn_done;
    // A timed-out image never passes; res_q is zeroed on timeout.
    assign chk_fail  = tmo_q || (res_q != exp_label);
    assign mismatch  = (state == S_CHECK) && chk_fail;

    // Batch sequencer: settle, start, wait for done edge, score, advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= S_IDLE;
            settle_cnt        <= '0;
            hold_cnt          <= '0;
            wdog              <= '0;
            done_prev         <= 1'b0;
            tmo_q             <= 1'b0;
            res_q             <= '0;
            img_idx           <= '0;
            cnn_start         <= 1'b0;
            busy              <= 1'b0;
            batch_done        <= 1'b0;
            all_pass          <= 1'b0;
            pass_cnt          <= '0;
            fail_cnt          <= '0;
            timeout_cnt       <= '0;
            first_fail_idx    <= '0;
            first_fail_result <= '0;
            first_fail_valid  <= 1'b0;
        end else if (abort && state != S_IDLE) begin
            state      <= S_IDLE;
            cnn_start  <= 1'b0;
            busy       <= 1'b0;
            batch_done <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (run && !abort) begin
                        pass_cnt          <= '0;
                        fail_cnt          <= '0;
                        timeout_cnt       <= '0;
                        first_fail_valid  <= 1'b0;
                        first_fail_idx    <= '0;
                        first_fail_result <= '0;
                        all_pass          <= 1'b0;
                        img_idx           <= '0;
                        settle_cnt        <= '0;
                        busy              <= 1'b1;
                        state             <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        hold_cnt  <= '0;
                        cnn_start <= 1'b1;
                        state     <= S_START;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                S_START: begin
                    done_prev <= cnn_done;
                    wdog      <= '0;
                    tmo_q     <= 1'b0;
                    if (hold_cnt == HOLD_LAST) begin
                        cnn_start <= 1'b0;
                        state     <= S_WAIT;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                S_WAIT: begin
                    done_prev <= cnn_done;
                    if (done_rise) begin
                        res_q <= cnn_result;
                        state <= S_CHECK;
                    end else if (wdog == WD_LIMIT) begin
                        res_q <= '0;
                        tmo_q <= 1'b1;
                        state <= S_CHECK;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                S_CHECK: begin
                    if (chk_fail) begin
                        fail_cnt <= fail_cnt + 1'b1;
                        if (tmo_q) begin
                            timeout_cnt <= timeout_cnt + 1'b1;
                        end
                        if (!first_fail_valid) begin
                            first_fail_idx    <= img_idx;
                            first_fail_result <= res_q;
                            first_fail_valid  <= 1'b1;
                        end
                    end else begin
                        pass_cnt <= pass_cnt + 1'b1;
                    end
                    state <= S_NEXT;
                end
                S_NEXT: begin
                    if (img_idx == IDX_LAST) begin
                        batch_done <= 1'b1;
                        all_pass   <= (fail_cnt == '0);
                        state      <= S_DONE;
                    end else begin
                        img_idx    <= img_idx + 1'b1;
                        settle_cnt <= '0;
                        state      <= S_SETTLE;
                    end
                end
                S_DONE: begin
                    batch_done <= 1'b0;
                    busy       <= 1'b0;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_batch_checker.sv
// Self-checking bench for cnn_batch_checker with a behavioural cnn_top.
// Expected per-image verdicts are queued and matched against observed ones.
module tb_cnn_batch_checker;

    localparam int NI = 4;
    localparam int SC = 4;
    localparam int SH = 2;
    localparam int TO = 200;

    logic       clk;
    logic       rst;
    logic       run;
    logic       abort;
    logic [3:0] img_idx;
    logic [3:0] exp_label;
    logic       cnn_start;
    logic       cnn_done;
    logic [3:0] cnn_result;
    logic       busy;
    logic       batch_done;
    logic       all_pass;
    logic [4:0] pass_cnt;
    logic [4:0] fail_cnt;
    logic [4:0] timeout_cnt;
    logic       mismatch;
    logic [3:0] first_fail_idx;
    logic [3:0] first_fail_result;
    logic       first_fail_valid;

    cnn_batch_checker #(
        .NUM_IMAGES(NI),
        .IDX_W(4),
        .CLASS_W(4),
        .CNT_W(5),
        .SETTLE_CYCLES(SC),
        .START_HOLD(SH),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .run(run),
        .abort(abort),
        .img_idx(img_idx),
        .exp_label(exp_label),
        .cnn_start(cnn_start),
        .cnn_done(cnn_done),
        .cnn_result(cnn_result),
        .busy(busy),
        .batch_done(batch_done),
        .all_pass(all_pass),
        .pass_cnt(pass_cnt),
        .fail_cnt(fail_cnt),
        .timeout_cnt(timeout_cnt),
        .mismatch(mismatch),
        .first_fail_idx(first_fail_idx),
        .first_fail_result(first_fail_result),
        .first_fail_valid(first_fail_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] idx;
        logic       fail;
        logic       tmo;
        logic       mis;
    } rec_t;

    rec_t exp_q[$];
    rec_t obs_q[$];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [3:0] lbl_of(input logic [3:0] i);
        case (i)
            4'd0:    return 4'd1;
            4'd1:    return 4'd7;
            4'd2:    return 4'd3;
            default: return 4'd0;
        endcase
    endfunction

    assign exp_label = lbl_of(img_idx);

    // behavioural cnn_top
    int         bad_img   = -1;
    int         hang_img  = -1;
    logic [3:0] bad_val   = 4'd0;
    bit         hold_mode = 1'b0;
    logic       start_q;
    bit         m_busy;
    int         m_cnt;
    int         m_idx;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            start_q    <= 1'b0;
            m_busy     <= 1'b0;
            m_cnt      <= 0;
            m_idx      <= 0;
            cnn_done   <= 1'b0;
            cnn_result <= 4'd0;
        end else begin
            start_q <= cnn_start;
            if (cnn_start && !start_q) begin
                m_busy <= 1'b1;
                m_cnt  <= 0;
                m_idx  <= int'(img_idx);
                if (!hold_mode) cnn_done <= 1'b0;
            end else if (m_busy) begin
                m_cnt <= m_cnt + 1;
                if (hold_mode && m_cnt == 5) cnn_done <= 1'b0;
                if (m_cnt == 99) begin
                    m_busy <= 1'b0;
                    if (m_idx != hang_img) begin
                        cnn_done   <= 1'b1;
                        cnn_result <= (m_idx == bad_img) ? bad_val : lbl_of(4'(m_idx));
                    end
                end
            end else if (!hold_mode) begin
                cnn_done <= 1'b0;
            end
        end
    end

    // monitor: one observation per counter increment
    int         bd_cnt  = 0;
    int         mis_cnt = 0;
    logic [4:0] pc_q    = 5'd0;
    logic [4:0] fc_q    = 5'd0;
    logic [4:0] tc_q    = 5'd0;
    logic       mis_q   = 1'b0;

    always @(negedge clk) begin
        if (pass_cnt == pc_q + 5'd1 || fail_cnt == fc_q + 5'd1)
            obs_q.push_back(rec_t'({img_idx, fail_cnt == fc_q + 5'd1,
                                    timeout_cnt == tc_q + 5'd1, mis_q}));
        if (batch_done === 1'b1) bd_cnt <= bd_cnt + 1;
        if (mismatch === 1'b1) mis_cnt <= mis_cnt + 1;
        pc_q  <= pass_cnt;
        fc_q  <= fail_cnt;
        tc_q  <= timeout_cnt;
        mis_q <= mismatch;
    end

    task automatic fresh();
        rst = 1'b1;
        run = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic kick();
        @(negedge clk);
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
    endtask

    task automatic wait_bd(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (batch_done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        run = 1'b0;
        abort = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        total++; if (cnn_start !== 1'b0) begin bad++; $display("FAIL rst_start: got %b want 0", cnn_start); end
        total++; if ({batch_done, all_pass, mismatch, first_fail_valid, img_idx, pass_cnt, fail_cnt,
                      timeout_cnt, first_fail_idx, first_fail_result} !== '0) begin
            bad++; $display("FAIL rst_outs: got nonzero want all 0");
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_all_pass();
        rec_t e, o;
        int   cyc, h, b0;
        bit   ok;
        fresh();
        for (int i = 0; i < NI; i++) exp_q.push_back(rec_t'({4'(i), 3'b000}));
        b0 = bd_cnt;
        @(negedge clk);
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        cyc = 1;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL ap_busy: got %b want 1", busy); end
        while (cnn_start !== 1'b1 && cyc < 50) begin @(negedge clk); cyc++; end
        total++; if (cyc != 1 + SC) begin bad++; $display("FAIL ap_start_lat: got %0d want %0d", cyc, 1 + SC); end
        h = 0;
        while (cnn_start === 1'b1 && h < 10) begin h++; @(negedge clk); end
        total++; if (h != SH) begin bad++; $display("FAIL ap_hold: got %0d want %0d", h, SH); end
        wait_bd(3000, ok);
        total++; if (!ok) begin bad++; $display("FAIL ap_bd_timeout: got none want batch_done"); end
        total++; if (pass_cnt !== 5'd4) begin bad++; $display("FAIL ap_pass: got %0d want 4", pass_cnt); end
        total++; if (fail_cnt !== 5'd0) begin bad++; $display("FAIL ap_fail: got %0d want 0", fail_cnt); end
        total++; if (all_pass !== 1'b1) begin bad++; $display("FAIL ap_allpass: got %b want 1", all_pass); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL ap_busy_done: got %b want 1", busy); end
        @(negedge clk);
        total++; if ({busy, batch_done} !== 2'b00) begin bad++; $display("FAIL ap_end: got %b want 00", {busy, batch_done}); end
        total++; if (all_pass !== 1'b1) begin bad++; $display("FAIL ap_allpass_hold: got %b want 1", all_pass); end
        repeat (2) @(negedge clk);
        total++; if (bd_cnt - b0 != 1) begin bad++; $display("FAIL ap_bd_pulses: got %0d want 1", bd_cnt - b0); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin bad++; $display("FAIL ap_sb: got none want %h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin bad++; $display("FAIL ap_sb: got %h want %h", o, e); end end
        end
        total++; if (obs_q.size() != 0) begin bad++; $display("FAIL ap_sb_extra: got %0d want 0", obs_q.size()); end
    endtask

    task automatic test_mismatch();
        rec_t e, o;
        int   m0;
        bit   ok;
        fresh();
        bad_img = 2;
        bad_val = 4'd5;
        for (int i = 0; i < NI; i++)
            exp_q.push_back(rec_t'({4'(i), (i == 2) ? 3'b101 : 3'b000}));
        m0 = mis_cnt;
        kick();
        wait_bd(3000, ok);
        total++; if (!ok) begin bad++; $display("FAIL mm_bd_timeout: got none want batch_done"); end
        total++; if (fail_cnt !== 5'd1) begin bad++; $display("FAIL mm_fail: got %0d want 1", fail_cnt); end
        total++; if (pass_cnt !== 5'd3) begin bad++; $display("FAIL mm_pass: got %0d want 3", pass_cnt); end
        total++; if (all_pass !== 1'b0) begin bad++; $display("FAIL mm_allpass: got %b want 0", all_pass); end
        total++; if (first_fail_valid !== 1'b1) begin bad++; $display("FAIL mm_ffv: got %b want 1", first_fail_valid); end
        total++; if (first_fail_idx !== 4'd2) begin bad++; $display("FAIL mm_ffidx: got %0d want 2", first_fail_idx); end
        total++; if (first_fail_result !== 4'd5) begin bad++; $display("FAIL mm_ffres: got %0d want 5", first_fail_result); end
        repeat (2) @(negedge clk);
        total++; if (mis_cnt - m0 != 1) begin bad++; $display("FAIL mm_pulses: got %0d want 1", mis_cnt - m0); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin bad++; $display("FAIL mm_sb: got none want %h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin bad++; $display("FAIL mm_sb: got %h want %h", o, e); end end
        end
        bad_img = -1;
    endtask

    task automatic test_timeout();
        rec_t e, o;
        bit   ok;
        fresh();
        hang_img = 1;
        for (int i = 0; i < NI; i++)
            exp_q.push_back(rec_t'({4'(i), (i == 1) ? 3'b111 : 3'b000}));
        kick();
        wait_bd(4000, ok);
        total++; if (!ok) begin bad++; $display("FAIL to_bd_timeout: got none want batch_done"); end
        total++; if (timeout_cnt !== 5'd1) begin bad++; $display("FAIL to_tcnt: got %0d want 1", timeout_cnt); end
        total++; if (fail_cnt !== 5'd1) begin bad++; $display("FAIL to_fail: got %0d want 1", fail_cnt); end
        total++; if (pass_cnt !== 5'd3) begin bad++; $display("FAIL to_pass: got %0d want 3", pass_cnt); end
        total++; if ({first_fail_valid, first_fail_idx, first_fail_result} !== {1'b1, 4'd1, 4'd0}) begin
            bad++; $display("FAIL to_ff: got %b/%0d/%0d want 1/1/0", first_fail_valid, first_fail_idx, first_fail_result);
        end
        repeat (2) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin bad++; $display("FAIL to_sb: got none want %h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin bad++; $display("FAIL to_sb: got %h want %h", o, e); end end
        end
        hang_img = -1;
    endtask

    task automatic test_hold_done();
        rec_t e, o;
        int   b0;
        bit   ok;
        fresh();
        hold_mode = 1'b1;
        for (int i = 0; i < NI; i++) exp_q.push_back(rec_t'({4'(i), 3'b000}));
        b0 = bd_cnt;
        kick();
        wait_bd(3000, ok);
        total++; if (!ok) begin bad++; $display("FAIL hd_bd_timeout: got none want batch_done"); end
        total++; if (pass_cnt !== 5'd4) begin bad++; $display("FAIL hd_pass: got %0d want 4", pass_cnt); end
        total++; if (fail_cnt !== 5'd0) begin bad++; $display("FAIL hd_fail: got %0d want 0", fail_cnt); end
        repeat (2) @(negedge clk);
        total++; if (bd_cnt - b0 != 1) begin bad++; $display("FAIL hd_bd_pulses: got %0d want 1", bd_cnt - b0); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin bad++; $display("FAIL hd_sb: got none want %h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin bad++; $display("FAIL hd_sb: got %h want %h", o, e); end end
        end
        total++; if (obs_q.size() != 0) begin bad++; $display("FAIL hd_sb_extra: got %0d want 0", obs_q.size()); end
        hold_mode = 1'b0;
    endtask

    task automatic test_abort();
        rec_t e, o;
        int   b0, cyc;
        bit   ok;
        fresh();
        for (int i = 0; i < 2; i++) exp_q.push_back(rec_t'({4'(i), 3'b000}));
        kick();
        cyc = 0;
        while (!(img_idx === 4'd2 && cnn_start === 1'b1) && cyc < 2000) begin @(negedge clk); cyc++; end
        while (cnn_start === 1'b1 && cyc < 2000) begin @(negedge clk); cyc++; end
        total++; if (cyc >= 2000) begin bad++; $display("FAIL ab_reach_img2: got timeout want img 2 wait"); end
        repeat (10) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        total++; if ({busy, cnn_start} !== 2'b00) begin bad++; $display("FAIL ab_stop: got %b want 00", {busy, cnn_start}); end
        total++; if ({pass_cnt, fail_cnt} !== {5'd2, 5'd0}) begin bad++; $display("FAIL ab_counts: got %0d/%0d want 2/0", pass_cnt, fail_cnt); end
        total++; if ({img_idx, all_pass} !== {4'd2, 1'b0}) begin bad++; $display("FAIL ab_idx: got %0d/%b want 2/0", img_idx, all_pass); end
        b0 = bd_cnt;
        repeat (150) @(negedge clk);
        total++; if (bd_cnt != b0) begin bad++; $display("FAIL ab_no_bd: got %0d want 0", bd_cnt - b0); end
        total++; if (pass_cnt !== 5'd2) begin bad++; $display("FAIL ab_frozen: got %0d want 2", pass_cnt); end
        @(negedge clk);
        run = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        run = 1'b0;
        abort = 1'b0;
        repeat (8) @(negedge clk);
        total++; if ({busy, cnn_start} !== 2'b00) begin bad++; $display("FAIL ab_run_abort: got %b want 00", {busy, cnn_start}); end
        total++; if (pass_cnt !== 5'd2) begin bad++; $display("FAIL ab_run_abort_cnt: got %0d want 2", pass_cnt); end
        for (int i = 0; i < NI; i++) exp_q.push_back(rec_t'({4'(i), 3'b000}));
        b0 = bd_cnt;
        kick();
        total++; if ({busy, pass_cnt, img_idx} !== {1'b1, 5'd0, 4'd0}) begin
            bad++; $display("FAIL ab_rerun_clr: got %b/%0d/%0d want 1/0/0", busy, pass_cnt, img_idx);
        end
        wait_bd(3000, ok);
        total++; if (!ok) begin bad++; $display("FAIL ab_rerun_bd: got none want batch_done"); end
        total++; if ({pass_cnt, all_pass} !== {5'd4, 1'b1}) begin bad++; $display("FAIL ab_rerun_res: got %0d/%b want 4/1", pass_cnt, all_pass); end
        repeat (2) @(negedge clk);
        total++; if (bd_cnt - b0 != 1) begin bad++; $display("FAIL ab_rerun_pulses: got %0d want 1", bd_cnt - b0); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin bad++; $display("FAIL ab_sb: got none want %h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin bad++; $display("FAIL ab_sb: got %h want %h", o, e); end end
        end
        total++; if (obs_q.size() != 0) begin bad++; $display("FAIL ab_sb_extra: got %0d want 0", obs_q.size()); end
    endtask

    task automatic test_rst_mid();
        rec_t e, o;
        int   cyc;
        bit   ok;
        fresh();
        exp_q.push_back(rec_t'({4'd0, 3'b000}));
        kick();
        cyc = 0;
        while (!(img_idx === 4'd1 && cnn_start === 1'b1) && cyc < 2000) begin @(negedge clk); cyc++; end
        total++; if (pass_cnt !== 5'd1 || cnn_start !== 1'b1) begin
            bad++; $display("FAIL rm_pre: got %0d/%b want 1/1", pass_cnt, cnn_start);
        end
        #1;
        rst = 1'b1;
        #1;
        total++; if (cnn_start !== 1'b0) begin bad++; $display("FAIL rm_start_async: got %b want 0", cnn_start); end
        total++; if ({busy, batch_done, all_pass, mismatch, first_fail_valid, img_idx, pass_cnt, fail_cnt,
                      timeout_cnt, first_fail_idx, first_fail_result} !== '0) begin
            bad++; $display("FAIL rm_outs: got nonzero want all 0");
        end
        @(negedge clk);
        rst = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin bad++; $display("FAIL rm_sb: got none want %h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin bad++; $display("FAIL rm_sb: got %h want %h", o, e); end end
        end
        for (int i = 0; i < NI; i++) exp_q.push_back(rec_t'({4'(i), 3'b000}));
        kick();
        total++; if ({busy, img_idx} !== {1'b1, 4'd0}) begin bad++; $display("FAIL rm_restart: got %b/%0d want 1/0", busy, img_idx); end
        wait_bd(3000, ok);
        total++; if (!ok) begin bad++; $display("FAIL rm_bd: got none want batch_done"); end
        total++; if ({pass_cnt, all_pass} !== {5'd4, 1'b1}) begin bad++; $display("FAIL rm_res: got %0d/%b want 4/1", pass_cnt, all_pass); end
        repeat (2) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin bad++; $display("FAIL rm_sb2: got none want %h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin bad++; $display("FAIL rm_sb2: got %h want %h", o, e); end end
        end
    endtask

    initial begin
        rst = 1'b1;
        run = 1'b0;
        abort = 1'b0;
        test_reset();
        test_all_pass();
        test_mismatch();
        test_timeout();
        test_hold_done();
        test_abort();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cnn_batch_checker.md
# cnn_batch_checker

On-chip batch regression controller for the digit-classifier accelerator. It sequences `cnn_top` through `NUM_IMAGES` stored test images, one `start`/`done` transaction per image, and compares each predicted digit against an expected label. It accumulates pass, fail and timeout statistics and captures the first failing image. It sits beside `cnn_top` and the image/label ROMs and replaces single-image manual checking with a synthesizable multi-image check that includes a watchdog.

## Interface
- `NUM_IMAGES`, 16: images per batch; range 1..2^IDX_W.
- `IDX_W`, 4: image index width.
- `CLASS_W`, 4: class/result width.
- `CNT_W`, 5: statistic counter width; 2^CNT_W > NUM_IMAGES.
- `SETTLE_CYCLES`, 4: idle cycles after an index change before start; must be ≥1.
- `START_HOLD`, 2: cycles `cnn_start` is held high; must be ≥1.
- `TIMEOUT_CYCLES`, 1048576: watchdog limit per image, in cycles.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `run`  in  1  start a batch; sampled only in IDLE.
- `abort`  in  1  cancel the batch; highest priority after `rst`.
- `img_idx`  out  IDX_W  current image index to the image loader and label ROM.
- `exp_label`  in  CLASS_W  expected label for `img_idx`; combinationally valid.
- `cnn_start`  out  1  start request to `cnn_top`.
- `cnn_done`  in  1  completion flag from `cnn_top`; a level, not a pulse.
- `cnn_result`  in  CLASS_W  prediction from `cnn_top`.
- `busy`  out  1  high from run acceptance until DONE or abort.
- `batch_done`  out  1  one-cycle pulse when the batch completes.
- `all_pass`  out  1  high after a completed batch if `fail_cnt` is 0.
- `pass_cnt`, `fail_cnt`, `timeout_cnt`  out  CNT_W  statistics.
- `mismatch`  out  1  one-cycle pulse per failing image.
- `first_fail_idx`  out  IDX_W  index of the first failing image.
- `first_fail_result`  out  CLASS_W  result (or 0 if timed out) of the first failure.
- `first_fail_valid`  out  1  `first_fail_*` registers hold data.

## Operation
- States: IDLE, SETTLE, START, WAIT_DONE, CHECK, NEXT, DONE.
- IDLE:
  - On `run`=1, clear all counters, `first_fail_valid`, `all_pass` and `img_idx`, then go to SETTLE.
  - `run` is ignored in all other states.
- SETTLE: count `SETTLE_CYCLES`, then go to START.
- START:
  - `cnn_start`=1 for exactly `START_HOLD` cycles, then go to WAIT_DONE.
  - Clear the watchdog and capture `cnn_done` into the edge register.
- WAIT_DONE:
  - Advance on a rising edge of `cnn_done` (prev=0, cur=1) only. If `done` is already high on entry, wait for it to fall and rise again.
  - On that edge, latch `cnn_result` and go to CHECK.
  - If the watchdog reaches `TIMEOUT_CYCLES`, set the internal timeout flag and go to CHECK.
- CHECK (1 cycle):
  - Pass when there is no timeout and the latched result equals `exp_label`; increment `pass_cnt`.
  - Otherwise increment `fail_cnt` and pulse `mismatch`. On a timeout, also increment `timeout_cnt`.
  - On the first failure only, load `first_fail_*` and set `first_fail_valid`.
- NEXT (1 cycle):
  - If `img_idx`==NUM_IMAGES-1, go to DONE.
  - Otherwise increment `img_idx` and go to SETTLE.
- DONE (1 cycle): `batch_done`=1 and `all_pass`=(fail_cnt==0), then go to IDLE with `busy`=0.
- Abort:
  - `abort`=1 in any non-IDLE state forces IDLE on the next edge: `cnn_start`=0, `busy`=0, no `batch_done`.
  - Statistics and `img_idx` hold their values; `all_pass` stays 0.
- Invariant: `pass_cnt`+`fail_cnt` equals the number of images checked; `timeout_cnt` ≤ `fail_cnt`.

## Timing
- Reset values: all outputs 0 and state IDLE.
- Run to `cnn_start` rising: 1 + SETTLE_CYCLES cycles.
- Per-image overhead excluding the accelerator: SETTLE_CYCLES + START_HOLD + 2 (CHECK, NEXT) + 1 (edge detect).
- `batch_done` is asserted one cycle after the final NEXT; `busy` falls in the same edge that deasserts `batch_done`.
- Counters update on the clock edge that exits CHECK. `mismatch` is high during the CHECK cycle.
- `img_idx` is stable from SETTLE entry through CHECK; `exp_label` is sampled in CHECK.
- `rst` mid-batch clears asynchronously: `cnn_start` drops immediately, all outputs go to 0.
- `abort` and `run` asserted together in IDLE: abort wins and the state stays IDLE.
- Watchdog compare is `==TIMEOUT_CYCLES`, counted from WAIT_DONE entry. A done edge in the same cycle as the limit counts as a pass candidate, not a timeout.

## Test plan
- NUM_IMAGES=4, labels {1,7,3,0}, and a behavioural `cnn_top` model that returns matching results after 100 cycles → `pass_cnt`=4, `fail_cnt`=0, `all_pass`=1, and one `batch_done` pulse.
- Same batch, but image 2 returns 5 → `fail_cnt`=1, `mismatch` pulses once, `first_fail_idx`=2, `first_fail_result`=5, `all_pass`=0.
- TIMEOUT_CYCLES=200 and image 1 never raises `done` → `timeout_cnt`=1, `fail_cnt`=1, and the batch still reaches `batch_done`.
- Model holds `done` high from the previous image until start → no double-count; each image is checked exactly once, totalling 4.
- `abort` during image 2 WAIT_DONE → `busy`=0 on the next edge, counts frozen at 2, and no `batch_done`. A subsequent `run` clears counts and completes normally.
- `rst` asserted mid-START → `cnn_start`=0 asynchronously, all outputs 0, state IDLE; a `run` after release restarts at `img_idx`=0.
